// File: rtl/control_fsm.sv
// Multi-cycle control FSM: fetch, decode, execute, memory and write-back
// sequencing for a small register-file CPU, with branch flags and halt.
module control_fsm #(
  parameter int unsigned N   = 8,
  parameter int unsigned PCW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  output logic           imem_req,
  output logic [PCW-1:0] imem_addr,
  input  logic           imem_ack,
  input  logic [23:0]    imem_data,
  output logic [4:0]     alu_ctrl,
  output logic           alu_b_imm,
  output logic [2:0]     rf_raddr_a,
  output logic [2:0]     rf_raddr_b,
  input  logic [N-1:0]   alu_result,
  output logic           rf_we,
  output logic [2:0]     rf_waddr,
  output logic           rf_wsel_mem,
  output logic           dmem_req,
  output logic           dmem_we,
  output logic [N-1:0]   dmem_addr,
  input  logic           dmem_ack,
  output logic [PCW-1:0] pc,
  output logic           halted,
  output logic           illegal_op
);

  localparam int unsigned OPW = 5;
  localparam int unsigned RW  = 3;

  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_EXECUTE   = 3'd2;
  localparam logic [2:0] S_MEMORY    = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;
  localparam logic [2:0] S_HALT      = 3'd5;

  localparam logic [OPW-1:0] OP_NOP  = 5'd0;
  localparam logic [OPW-1:0] OP_ADD  = 5'd1;
  localparam logic [OPW-1:0] OP_SUB  = 5'd2;
  localparam logic [OPW-1:0] OP_MUL  = 5'd3;
  localparam logic [OPW-1:0] OP_MOVE = 5'd4;
  localparam logic [OPW-1:0] OP_DIV  = 5'd5;
  localparam logic [OPW-1:0] OP_LNUM = 5'd6;
  localparam logic [OPW-1:0] OP_AND  = 5'd9;
  localparam logic [OPW-1:0] OP_OR   = 5'd10;
  localparam logic [OPW-1:0] OP_XOR  = 5'd11;
  localparam logic [OPW-1:0] OP_NOT  = 5'd12;
  localparam logic [OPW-1:0] OP_LDR  = 5'd17;
  localparam logic [OPW-1:0] OP_STR  = 5'd19;
  localparam logic [OPW-1:0] OP_JE   = 5'd25;
  localparam logic [OPW-1:0] OP_JNE  = 5'd26;
  localparam logic [OPW-1:0] OP_JGT  = 5'd27;
  localparam logic [OPW-1:0] OP_JGE  = 5'd28;
  localparam logic [OPW-1:0] OP_JLT  = 5'd29;
  localparam logic [OPW-1:0] OP_JLE  = 5'd30;
  localparam logic [OPW-1:0] OP_HALT = 5'd31;

  typedef struct packed {
    logic [OPW-1:0] op;
    logic [RW-1:0]  rd;
    logic [RW-1:0]  rs1;
    logic [RW-1:0]  rs2;
    logic [1:0]     rsvd;
    logic [7:0]     imm;
  } instr_t;

  function automatic logic is_alu(input logic [OPW-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_MOVE, OP_DIV, OP_LNUM,
      OP_AND, OP_OR, OP_XOR, OP_NOT: is_alu = 1'b1;
      default:                       is_alu = 1'b0;
    endcase
  endfunction

  function automatic logic is_branch(input logic [OPW-1:0] op);
    case (op)
      OP_JE, OP_JNE, OP_JGT, OP_JGE, OP_JLT, OP_JLE: is_branch = 1'b1;
      default:                                       is_branch = 1'b0;
    endcase
  endfunction

  function automatic logic is_mem(input logic [OPW-1:0] op);
    is_mem = (op == OP_LDR) || (op == OP_STR);
  endfunction

  function automatic logic is_legal(input logic [OPW-1:0] op);
    is_legal = is_alu(op) || is_branch(op) || is_mem(op) ||
               (op == OP_NOP) || (op == OP_HALT);
  endfunction

  logic [2:0]     state, state_nxt;
  logic [PCW-1:0] pc_nxt;
  instr_t         ir, ir_nxt;
  logic [N-1:0]   res, res_nxt;
  logic           z_flag, z_nxt;
  logic           nf_flag, nf_nxt;
  logic           branch_taken;

  logic           imem_req_nxt;
  logic [OPW-1:0] alu_ctrl_nxt;
  logic           alu_b_imm_nxt;
  logic [RW-1:0]  rf_raddr_a_nxt;
  logic [RW-1:0]  rf_raddr_b_nxt;
  logic           rf_we_nxt;
  logic [RW-1:0]  rf_waddr_nxt;
  logic           rf_wsel_mem_nxt;
  logic           dmem_req_nxt;
  logic           dmem_we_nxt;
  logic           halted_nxt;
  logic           illegal_op_nxt;

  logic           unused_rsvd;

  assign imem_addr   = pc;
  assign dmem_addr   = res;
  assign unused_rsvd = ^ir.rsvd;

  // Branch condition from the flags left by the most recent SUB
  always_comb begin
    branch_taken = 1'b0;
    case (ir.op)
      OP_JE:   branch_taken = z_flag;
      OP_JNE:  branch_taken = !z_flag;
      OP_JGT:  branch_taken = !z_flag && !nf_flag;
      OP_JGE:  branch_taken = !nf_flag;
      OP_JLT:  branch_taken = nf_flag;
      OP_JLE:  branch_taken = z_flag || nf_flag;
      default: branch_taken = 1'b0;
    endcase
  end

  // Next state, architectural updates and next values of the registered outputs
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_nxt    = ir;
    res_nxt   = res;
    z_nxt     = z_flag;
    nf_nxt    = nf_flag;

    case (state)
      S_FETCH: begin
        if (imem_req && imem_ack) begin
          ir_nxt    = instr_t'(imem_data);
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: state_nxt = S_EXECUTE;
      S_EXECUTE: begin
        res_nxt = alu_result;
        if (ir.op == OP_SUB) begin
          z_nxt  = (alu_result == '0);
          nf_nxt = alu_result[N-1];
        end
        if (is_alu(ir.op)) begin
          state_nxt = S_WRITEBACK;
        end else if (is_mem(ir.op)) begin
          state_nxt = S_MEMORY;
        end else if (ir.op == OP_HALT) begin
          state_nxt = S_HALT;
        end else if (is_branch(ir.op)) begin
          state_nxt = S_FETCH;
          pc_nxt    = branch_taken ? PCW'(ir.imm) : pc + PCW'(1);
        end else begin
          state_nxt = S_FETCH;
          pc_nxt    = pc + PCW'(1);
        end
      end
      S_MEMORY: begin
        if (dmem_req && dmem_ack) begin
          if (ir.op == OP_LDR) begin
            state_nxt = S_WRITEBACK;
          end else begin
            state_nxt = S_FETCH;
            pc_nxt    = pc + PCW'(1);
          end
        end
      end
      S_WRITEBACK: begin
        state_nxt = S_FETCH;
        pc_nxt    = pc + PCW'(1);
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_FETCH;
    endcase

    // Outputs are registered but decoded from the next state so they line up with it
    imem_req_nxt    = (state_nxt == S_FETCH);
    alu_ctrl_nxt    = '0;
    alu_b_imm_nxt   = 1'b0;
    rf_raddr_a_nxt  = '0;
    rf_raddr_b_nxt  = '0;
    rf_we_nxt       = 1'b0;
    rf_waddr_nxt    = '0;
    rf_wsel_mem_nxt = 1'b0;
    dmem_req_nxt    = (state_nxt == S_MEMORY);
    dmem_we_nxt     = (state_nxt == S_MEMORY) && (ir_nxt.op == OP_STR);
    halted_nxt      = (state_nxt == S_HALT);
    illegal_op_nxt  = (state_nxt == S_DECODE) && !is_legal(ir_nxt.op);

    if ((state_nxt == S_DECODE) || (state_nxt == S_EXECUTE) || (state_nxt == S_MEMORY)) begin
      rf_raddr_a_nxt = ir_nxt.rs1;
      rf_raddr_b_nxt = ((state_nxt == S_MEMORY) && (ir_nxt.op == OP_STR)) ? ir_nxt.rd : ir_nxt.rs2;
    end

    if (state_nxt == S_EXECUTE) begin
      if (is_alu(ir_nxt.op) || is_mem(ir_nxt.op)) begin
        alu_ctrl_nxt = ir_nxt.op;
      end
      alu_b_imm_nxt = (ir_nxt.op == OP_LNUM) || is_mem(ir_nxt.op);
    end

    if (state_nxt == S_WRITEBACK) begin
      rf_we_nxt       = 1'b1;
      rf_waddr_nxt    = ir_nxt.rd;
      rf_wsel_mem_nxt = (ir_nxt.op == OP_LDR);
    end
  end

  // State, architectural registers and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_FETCH;
      pc          <= '0;
      ir          <= '0;
      res         <= '0;
      z_flag      <= 1'b0;
      nf_flag     <= 1'b0;
      imem_req    <= 1'b0;
      alu_ctrl    <= '0;
      alu_b_imm   <= 1'b0;
      rf_raddr_a  <= '0;
      rf_raddr_b  <= '0;
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wsel_mem <= 1'b0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      halted      <= 1'b0;
      illegal_op  <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      ir          <= ir_nxt;
      res         <= res_nxt;
      z_flag      <= z_nxt;
      nf_flag     <= nf_nxt;
      imem_req    <= imem_req_nxt;
      alu_ctrl    <= alu_ctrl_nxt;
      alu_b_imm   <= alu_b_imm_nxt;
      rf_raddr_a  <= rf_raddr_a_nxt;
      rf_raddr_b  <= rf_raddr_b_nxt;
      rf_we       <= rf_we_nxt;
      rf_waddr    <= rf_waddr_nxt;
      rf_wsel_mem <= rf_wsel_mem_nxt;
      dmem_req    <= dmem_req_nxt;
      dmem_we     <= dmem_we_nxt;
      halted      <= halted_nxt;
      illegal_op  <= illegal_op_nxt;
    end
  end

endmodule
